// File: rtl/dram_copy_engine.sv
// dram_copy_engine
//   Block copier sitting on the DRAM controller user interface in the user
//   clock domain. A job copies JOB_ELEM blocks from JOB_SRC to JOB_DST, one
//   chunk of up to 2**CHUNK_LOG blocks at a time. Each chunk is first read
//   into a local show-ahead buffer and then written back out.
//
// Ports
//   CLK, RST_X                 user clock, asynchronous active-low reset
//   JOB_GO/SRC/DST/ELEM        job start pulse and parameters (sampled in IDLE)
//   JOB_BUSY, JOB_DONE         job in flight / one-cycle completion pulse
//   D_REQ, D_INITADR, D_ELEM   request to the controller (D_REQ is one cycle wide)
//   D_DIN, D_W                 write data (buffer head) and its consume strobe
//   D_DOUT, D_DOUTEN           read data and its valid strobe
//   D_BUSY                     controller is executing a request

`ifndef APPDATA_WIDTH
`define APPDATA_WIDTH 128
`endif
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif
`ifndef MEM_LAST_ADDR
`define MEM_LAST_ADDR 32'h03FF_FFF8
`endif

module dram_copy_engine #(
  parameter int unsigned CHUNK_LOG = 4,
  parameter int unsigned DW        = `APPDATA_WIDTH
) (
  input  logic          CLK,
  input  logic          RST_X,
  input  logic          JOB_GO,
  input  logic [31:0]   JOB_SRC,
  input  logic [31:0]   JOB_DST,
  input  logic [31:0]   JOB_ELEM,
  output logic          JOB_BUSY,
  output logic          JOB_DONE,
  output logic [1:0]    D_REQ,
  output logic [31:0]   D_INITADR,
  output logic [31:0]   D_ELEM,
  output logic [DW-1:0] D_DIN,
  input  logic          D_W,
  input  logic [DW-1:0] D_DOUT,
  input  logic          D_DOUTEN,
  input  logic          D_BUSY
);

  localparam int unsigned DEPTH    = 1 << CHUNK_LOG;
  localparam logic [31:0] LAST     = `MEM_LAST_ADDR;
  localparam logic [1:0]  REQ_RD   = `DRAM_REQ_READ;
  localparam logic [1:0]  REQ_WR   = `DRAM_REQ_WRITE;
  localparam logic [CHUNK_LOG:0] DEPTH_N = (CHUNK_LOG+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [31:0]          r_src, r_dst, r_rem;
  logic [CHUNK_LOG:0]   r_n;
  logic [31:0]          r_initadr, r_elem;

  logic [DW-1:0]        r_mem [DEPTH];
  logic [CHUNK_LOG-1:0] r_wptr, r_rptr;
  logic [CHUNK_LOG:0]   r_count;

  logic                 w_rd_issue, w_wr_issue, w_push, w_pop, w_chunk_done;
  logic [CHUNK_LOG:0]   w_n;

  // Advance an address by n blocks, wrapping exactly like the controller so
  // a chunk that crosses the end of memory stays contiguous.
  function automatic logic [31:0] f_advance(input logic [31:0] cur,
                                            input logic [CHUNK_LOG:0] n);
    logic [31:0] nxt;
    nxt = cur + (32'(n) << 3);
    if (nxt > LAST) nxt = nxt - (LAST + 32'd8);
    return nxt;
  endfunction

  assign w_n          = (r_rem < 32'(DEPTH)) ? r_rem[CHUNK_LOG:0] : DEPTH_N;
  assign w_rd_issue   = (r_state == S_RD_REQ) && !D_BUSY;
  assign w_wr_issue   = (r_state == S_WR_REQ) && !D_BUSY;
  assign w_push       = (r_state == S_RD_WAIT) && D_DOUTEN;
  assign w_pop        = (r_state == S_WR_WAIT) && D_W;
  assign w_chunk_done = (r_state == S_WR_WAIT) && (r_count == '0) && !D_BUSY;

  // Request outputs are combinational in the issue cycle only; the address
  // and length are captured then so they hold until the next issue.
  always_comb begin
    w_next    = r_state;
    D_REQ     = '0;
    D_INITADR = r_initadr;
    D_ELEM    = r_elem;
    JOB_BUSY  = (r_state != S_IDLE);
    JOB_DONE  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (JOB_GO) w_next = (JOB_ELEM == '0) ? S_DONE : S_RD_REQ;
      end
      S_RD_REQ: begin
        if (w_rd_issue) begin
          D_REQ     = REQ_RD;
          D_INITADR = r_src;
          D_ELEM    = 32'(w_n);
          w_next    = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if ((r_count == r_n) && !D_BUSY) w_next = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (w_wr_issue) begin
          D_REQ     = REQ_WR;
          D_INITADR = r_dst;
          D_ELEM    = 32'(r_n);
          w_next    = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // rem is updated in the same edge, so "rem - n == 0" is tested as rem == n
        if (w_chunk_done) w_next = (r_rem == 32'(r_n)) ? S_DONE : S_RD_REQ;
      end
      S_DONE: begin
        JOB_DONE = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_rem     <= '0;
      r_n       <= '0;
      r_initadr <= '0;
      r_elem    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && JOB_GO) begin
        r_src <= JOB_SRC;
        r_dst <= JOB_DST;
        r_rem <= JOB_ELEM;
      end
      if (w_rd_issue) r_n <= w_n;
      if (w_rd_issue || w_wr_issue) begin
        r_initadr <= D_INITADR;
        r_elem    <= D_ELEM;
      end
      if (w_chunk_done) begin
        r_src <= f_advance(r_src, r_n);
        r_dst <= f_advance(r_dst, r_n);
        r_rem <= r_rem - 32'(r_n);
      end
    end
  end

  // Chunk buffer. Storage is reset too so D_DIN reads zero out of reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= D_DOUT;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      // push and pop live in different states and never coincide
      if (w_push)     r_count <= r_count + 1'b1;
      else if (w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign D_DIN = r_mem[r_rptr];

  a_no_overflow:  assert property (@(posedge CLK) disable iff (!RST_X)
                                   !(w_push && (r_count == DEPTH_N)));
  a_no_underflow: assert property (@(posedge CLK) disable iff (!RST_X)
                                   !(w_pop && (r_count == '0)));

endmodule

// File: tb/tb_dram_copy_engine.sv
`ifndef APPDATA_WIDTH
`define APPDATA_WIDTH 128
`endif
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif
`ifndef MEM_LAST_ADDR
`define MEM_LAST_ADDR 32'h03FF_FFF8
`endif

module tb_dram_copy_engine;

  localparam int unsigned CL    = 4;
  localparam int unsigned DW    = `APPDATA_WIDTH;
  localparam int unsigned MAXN  = 1 << CL;
  localparam logic [31:0] LAST  = `MEM_LAST_ADDR;
  localparam logic [1:0]  RQ_RD = `DRAM_REQ_READ;
  localparam logic [1:0]  RQ_WR = `DRAM_REQ_WRITE;

  logic          CLK = 1'b0;
  logic          RST_X = 1'b1;
  logic          JOB_GO = 1'b0;
  logic [31:0]   JOB_SRC = '0, JOB_DST = '0, JOB_ELEM = '0;
  logic          JOB_BUSY, JOB_DONE;
  logic [1:0]    D_REQ;
  logic [31:0]   D_INITADR, D_ELEM;
  logic [DW-1:0] D_DIN;
  logic          D_W = 1'b0;
  logic [DW-1:0] D_DOUT = '0;
  logic          D_DOUTEN = 1'b0;
  logic          D_BUSY = 1'b0;

  dram_copy_engine #(.CHUNK_LOG(CL), .DW(DW)) dut (
    .CLK(CLK), .RST_X(RST_X), .JOB_GO(JOB_GO), .JOB_SRC(JOB_SRC),
    .JOB_DST(JOB_DST), .JOB_ELEM(JOB_ELEM), .JOB_BUSY(JOB_BUSY),
    .JOB_DONE(JOB_DONE), .D_REQ(D_REQ), .D_INITADR(D_INITADR),
    .D_ELEM(D_ELEM), .D_DIN(D_DIN), .D_W(D_W), .D_DOUT(D_DOUT),
    .D_DOUTEN(D_DOUTEN), .D_BUSY(D_BUSY)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] elem;
  } req_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] dmem [logic [31:0]];   // DRAM contents seen by the controller model
  req_t          exp_q [$];             // expected request stream for the current job
  logic [DW-1:0] src_blk [$];           // source data snapshot for the current job

  int  done_cnt   = 0;
  int  wr_beats   = 0;
  int  job_seq    = 0;
  int  gap_max    = 1;
  bit  stall_mode = 1'b0;
  bit  ctl_abort  = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got,
                          input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory is a ring of (LAST+8) address units; block k of a region lives here.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input longint unsigned off);
    return 32'((longint'(a) + off) % (longint'(LAST) + 64'd8));
  endfunction

  function automatic logic [DW-1:0] rand_blk();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW); i += 32) v[i +: 32] = $urandom;
    return v;
  endfunction

  // Reference model: chunk list and data image derived from the job alone.
  task automatic prep_job(input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] elem);
    longint unsigned r;
    longint unsigned n;
    logic [31:0] s, d;
    logic [DW-1:0] v;
    exp_q.delete();
    src_blk.delete();
    for (longint unsigned k = 0; k < elem; k++) begin
      v = rand_blk();
      dmem[wrap_add(src, 8 * k)] = v;
      dmem[wrap_add(dst, 8 * k)] = ~v;
      src_blk.push_back(v);
    end
    r = elem; s = src; d = dst;
    while (r != 0) begin
      n = (r < MAXN) ? r : MAXN;
      exp_q.push_back('{RQ_RD, s, 32'(n)});
      exp_q.push_back('{RQ_WR, d, 32'(n)});
      s = wrap_add(s, 8 * n);
      d = wrap_add(d, 8 * n);
      r = r - n;
    end
  endtask

  task automatic launch_job(input logic [31:0] src, input logic [31:0] dst,
                            input logic [31:0] elem);
    @(posedge CLK); #1;
    JOB_SRC = src; JOB_DST = dst; JOB_ELEM = elem; JOB_GO = 1'b1;
    job_seq++;
    @(posedge CLK); #1;
    JOB_GO = 1'b0;
    JOB_SRC = $urandom; JOB_DST = $urandom; JOB_ELEM = $urandom;
  endtask

  task automatic finish_job(input logic [31:0] dst, input logic [31:0] elem,
                            input int d0, input int w0, input bit stray);
    int cyc;
    bit got;
    @(negedge CLK);
    check_eq("busy_after_go", JOB_BUSY, 1'b1);
    cyc = 1;
    got = JOB_DONE;
    while (!got && cyc < 20000) begin
      @(negedge CLK);
      cyc++;
      if (stray && cyc == 10) JOB_GO = 1'b1;
      if (cyc == 11) JOB_GO = 1'b0;
      got = JOB_DONE;
    end
    JOB_GO = 1'b0;
    check_eq("done_seen", got, 1'b1);
    if (elem == 0) check_eq("zero_done_latency", cyc, 1);
    @(negedge CLK);
    check_eq("done_width", JOB_DONE, 1'b0);
    check_eq("busy_clear", JOB_BUSY, 1'b0);
    repeat (5) @(negedge CLK);
    check_eq("done_count", done_cnt - d0, 1);
    check_eq("reqs_left", exp_q.size(), 0);
    check_eq("write_beats", wr_beats - w0, elem);
    for (longint unsigned k = 0; k < elem; k++)
      check_eq("dst_data", dmem[wrap_add(dst, 8 * k)], src_blk[k]);
  endtask

  task automatic do_job(input logic [31:0] src, input logic [31:0] dst,
                        input logic [31:0] elem, input bit stray);
    int d0, w0;
    prep_job(src, dst, elem);
    d0 = done_cnt;
    w0 = wr_beats;
    launch_job(src, dst, elem);
    finish_job(dst, elem, d0, w0, stray);
  endtask

  // Controller model: one request at a time, busy rises the cycle after it
  // samples D_REQ, data beats with random gaps, optional long busy stalls.
  task automatic xfer();
    logic [1:0]  kind;
    logic [31:0] a, a0, n;
    req_t        e;
    int          g;
    kind = D_REQ; a = D_INITADR; a0 = D_INITADR; n = D_ELEM;
    if (exp_q.size() == 0) check_eq("req_unexpected", D_REQ, 2'b00);
    else begin
      e = exp_q.pop_front();
      check_eq("req_kind", kind, e.kind);
      check_eq("req_addr", a, e.addr);
      check_eq("req_elem", n, e.elem);
    end
    @(negedge CLK);
    check_eq("req_one_cycle", D_REQ, 2'b00);
    @(posedge CLK); #1;
    D_BUSY = 1'b1;
    for (int unsigned k = 0; k < n && !ctl_abort; k++) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin @(posedge CLK); #1; end
      if (kind == RQ_RD) begin
        D_DOUT   = dmem.exists(a) ? dmem[a] : '0;
        D_DOUTEN = 1'b1;
        @(posedge CLK); #1;
        D_DOUTEN = 1'b0;
      end else begin
        D_W = 1'b1;
        @(negedge CLK);
        dmem[a] = D_DIN;
        wr_beats++;
        @(posedge CLK); #1;
        D_W = 1'b0;
      end
      a = wrap_add(a, 8);
    end
    g = $urandom_range(0, 2) + (stall_mode ? 50 : 0);
    for (int j = 0; j < g && !ctl_abort; j++) begin @(posedge CLK); #1; end
    D_BUSY = 1'b0;
    if (!ctl_abort) begin
      check_eq("hold_addr", D_INITADR, a0);
      check_eq("hold_elem", D_ELEM, n);
    end
  endtask

  initial begin : ctrl
    int last_seq;
    last_seq = 0;
    forever begin
      @(negedge CLK);
      if (job_seq != last_seq) begin
        last_seq = job_seq;
        if (stall_mode) begin
          D_BUSY = 1'b1;
          for (int j = 0; j < 50 && !ctl_abort; j++) @(posedge CLK);
          #1 D_BUSY = 1'b0;
        end
      end else if (!ctl_abort && D_REQ != 2'b00) begin
        xfer();
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge CLK);
      if (JOB_DONE) done_cnt++;
      if (D_REQ != 2'b00) check_eq("req_while_busy", D_BUSY, 1'b0);
    end
  end

  initial begin : main
    logic [31:0] s, d, e;
    int cyc, d0, w0;

    #1 RST_X = 1'b0;
    #2;
    check_eq("rst_req", D_REQ, 2'b00);
    check_eq("rst_busy", JOB_BUSY, 1'b0);
    check_eq("rst_done", JOB_DONE, 1'b0);
    check_eq("rst_adr", D_INITADR, 32'h0);
    check_eq("rst_elem", D_ELEM, 32'h0);
    check_eq("rst_din", D_DIN, '0);
    repeat (3) @(negedge CLK);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);

    do_job(32'h0000_0000, 32'h0000_1000, 16, 1'b0);
    do_job(32'h0000_0000, 32'h0000_4000, 37, 1'b0);
    do_job(32'h0000_0100, 32'h0000_0200, 0, 1'b0);
    do_job(LAST - 32'h38, 32'h0000_8000, 20, 1'b0);

    stall_mode = 1'b1;
    gap_max    = 3;
    for (int i = 0; i < 2; i++) begin
      s = $urandom_range(0, 32'h007F_FFFF) << 3;
      d = wrap_add(s, 64'h10_0000);
      e = $urandom_range(17, 60);
      do_job(s, d, e, 1'b1);
    end
    stall_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = $urandom_range(0, 32'h007F_FFFF) << 3;
      d = wrap_add(s, 64'h20_0000);
      e = $urandom_range(17, 70);
      do_job(s, d, e, 1'b1);
    end

    // reset while the write-back of a chunk is in progress
    prep_job(32'h0000_2000, 32'h0000_6000, 16);
    w0 = wr_beats;
    launch_job(32'h0000_2000, 32'h0000_6000, 16);
    cyc = 0;
    while ((wr_beats - w0) < 5 && cyc < 5000) begin @(negedge CLK); cyc++; end
    check_eq("reach_write", ((wr_beats - w0) >= 5), 1'b1);
    @(posedge CLK); #3;
    RST_X = 1'b0;
    ctl_abort = 1'b1;
    #1;
    check_eq("arst_req", D_REQ, 2'b00);
    check_eq("arst_busy", JOB_BUSY, 1'b0);
    check_eq("arst_done", JOB_DONE, 1'b0);
    check_eq("arst_adr", D_INITADR, 32'h0);
    check_eq("arst_elem", D_ELEM, 32'h0);
    check_eq("arst_din", D_DIN, '0);
    d0 = done_cnt;
    repeat (20) @(negedge CLK);
    check_eq("arst_no_done", done_cnt - d0, 0);
    exp_q.delete();
    ctl_abort = 1'b0;
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
    check_eq("post_rst_idle", JOB_BUSY, 1'b0);
    do_job(32'h0000_3000, 32'h0000_7000, 21, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
